// File: rtl/shift_two_rx_if.sv
// shift_two_rx_if: symbol-in / byte-out bus between the PPM slot decoder, the receive shifter and the byte sink
interface shift_two_rx_if;
    logic [1:0] sym_in;
    logic       sym_valid;
    logic       sync;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        output sym_in, sym_valid, sync,
        input  data_out, data_valid, frame_err, busy
    );

    modport slave (
        input  sym_in, sym_valid, sync,
        output data_out, data_valid, frame_err, busy
    );
endinterface

// File: rtl/shift_two_rx.sv
// shift_two_rx: assembles 2-bit PPM symbols (MSB pair first) into bytes, dropping partial bytes on timeout or sync
module shift_two_rx #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic           clk,
    input  logic           rst,
    shift_two_rx_if.slave  bus
);
    typedef enum logic {IDLE, COLLECT} state_t;

    localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_q, state_d;
    logic [1:0]       sym_cnt_q, sym_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [5:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic             dv_q, dv_d;
    logic             fe_q, fe_d;

    // Next state: sync (or an idle receiver) restarts the byte, otherwise shift in a symbol or age the gap counter
    always_comb begin
        state_d   = state_q;
        sym_cnt_d = sym_cnt_q;
        gap_cnt_d = gap_cnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        fe_d      = 1'b0;
        if (bus.sync || state_q == IDLE) begin
            fe_d      = bus.sync && state_q == COLLECT;
            state_d   = bus.sym_valid ? COLLECT : IDLE;
            sym_cnt_d = bus.sym_valid ? 2'd1 : 2'd0;
            gap_cnt_d = '0;
            shreg_d   = bus.sym_valid ? {4'b0, bus.sym_in} : '0;
        end else if (bus.sym_valid) begin
            shreg_d   = {shreg_q[3:0], bus.sym_in};
            sym_cnt_d = sym_cnt_q + 2'd1;
            gap_cnt_d = '0;
            if (sym_cnt_q == 2'd3) begin
                data_d  = {shreg_q, bus.sym_in};
                dv_d    = 1'b1;
                state_d = IDLE;
            end
        end else if (gap_cnt_q == GAP_MAX) begin
            fe_d      = 1'b1;
            state_d   = IDLE;
            sym_cnt_d = 2'd0;
            gap_cnt_d = '0;
            shreg_d   = '0;
        end else begin
            gap_cnt_d = gap_cnt_q + CNT_W'(1);
        end
    end

    // State and output registers; reset silently discards any partial byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sym_cnt_q <= 2'd0;
            gap_cnt_q <= '0;
            shreg_q   <= '0;
            data_q    <= 8'h00;
            dv_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sym_cnt_q <= sym_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            fe_q      <= fe_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = dv_q;
    assign bus.frame_err  = fe_q;
    assign bus.busy       = state_q == COLLECT;
endmodule
